// File: rtl/asic_iopwrseq.sv
// asic_iopwrseq: ordered padring segment power-up/down sequencer with pg monitor and fault latch
module asic_iopwrseq #(
    parameter int NSEG  = 4,
    parameter int NCTRL = 8,
    parameter int CNTW  = 8,
    parameter int SW    = (NSEG > 1) ? $clog2(NSEG) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic [NCTRL-1:0]      cfg,
    input  logic [CNTW-1:0]       settle_cycles,
    input  logic [CNTW-1:0]       timeout_cycles,
    input  logic [NSEG-1:0]       pg,
    output logic [NSEG-1:0]       seg_en,
    output logic [NSEG*NCTRL-1:0] ctrlring,
    output logic                  busy,
    output logic                  ready,
    output logic                  fault,
    output logic [SW-1:0]         fault_seg
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RAMP   = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] UP     = 3'd3;
    localparam logic [2:0] DOWN   = 3'd4;
    localparam logic [2:0] FAULT  = 3'd5;
    localparam logic [SW-1:0] LAST = SW'(NSEG - 1);

    logic [2:0]       state, state_n;
    logic [SW-1:0]    idx, idx_n, fseg_n, low_bad;
    logic [CNTW-1:0]  cnt, cnt_n, s_last;
    logic [NSEG-1:0]  seg_n, pg_sh, one_hot, below, watch, bad;
    logic [NCTRL-1:0] cfg_q, cfg_n;
    logic             pg_cur, s_done;

    // settle_cycles of 0 behaves as 1, so the terminal count is S-1 clamped at 0
    assign s_last  = (settle_cycles == '0) ? '0 : settle_cycles - CNTW'(1);
    assign s_done  = cnt == s_last;
    assign pg_sh   = pg >> idx;
    assign pg_cur  = pg_sh[0];
    assign one_hot = NSEG'(1) << idx;
    assign below   = one_hot - NSEG'(1);
    assign bad     = watch & ~pg;

    // segments whose power-good is monitored: settled ones, plus the current one while settling
    always_comb begin
        watch = (state == UP)     ? '1 :
                (state == SETTLE) ? (below | one_hot) :
                (state == RAMP)   ? below : '0;
    end

    // lowest-index failing segment among the monitored set
    always_comb begin
        low_bad = '0;
        for (int i = NSEG - 1; i >= 0; i--)
            if (bad[i]) low_bad = SW'(i);
    end

    // next-state logic; seg_en is always a thermometer code so shifts add/remove the top segment
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        seg_n   = seg_en;
        cfg_n   = cfg_q;
        fseg_n  = fault_seg;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    cfg_n   = cfg;
                    idx_n   = '0;
                    seg_n   = NSEG'(1);
                    cnt_n   = '0;
                    state_n = RAMP;
                end
            end
            RAMP, SETTLE, UP: begin
                if (|bad) begin
                    state_n = FAULT;
                    seg_n   = '0;
                    fseg_n  = low_bad;
                end else if (state == RAMP && !pg_cur && cnt == timeout_cycles) begin
                    state_n = FAULT;
                    seg_n   = '0;
                    fseg_n  = idx;
                end else if (stop) begin
                    seg_n   = seg_en >> 1;
                    cnt_n   = '0;
                    state_n = ((seg_en >> 1) == '0) ? IDLE : DOWN;
                end else if (state == RAMP) begin
                    if (pg_cur) begin
                        cnt_n   = '0;
                        state_n = SETTLE;
                    end else begin
                        cnt_n = cnt + CNTW'(1);
                    end
                end else if (state == SETTLE) begin
                    if (s_done) begin
                        cnt_n = '0;
                        if (idx == LAST) begin
                            state_n = UP;
                        end else begin
                            idx_n   = idx + SW'(1);
                            seg_n   = (seg_en << 1) | NSEG'(1);
                            state_n = RAMP;
                        end
                    end else begin
                        cnt_n = cnt + CNTW'(1);
                    end
                end
            end
            DOWN: begin
                if (s_done) begin
                    seg_n = seg_en >> 1;
                    cnt_n = '0;
                    if ((seg_en >> 1) == '0) state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNTW'(1);
                end
            end
            FAULT: begin
                if (clear) begin
                    state_n = IDLE;
                    fseg_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
                seg_n   = '0;
            end
        endcase
    end

    // state and registered outputs, all derived from the next-state values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            cfg_q     <= '0;
            seg_en    <= '0;
            ctrlring  <= '0;
            busy      <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
            fault_seg <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            cfg_q     <= cfg_n;
            seg_en    <= seg_n;
            busy      <= (state_n == RAMP) || (state_n == SETTLE) || (state_n == DOWN);
            ready     <= state_n == UP;
            fault     <= state_n == FAULT;
            fault_seg <= fseg_n;
            for (int i = 0; i < NSEG; i++)
                ctrlring[i*NCTRL +: NCTRL] <= seg_n[i] ? cfg_n : '0;
        end
    end
endmodule

// File: tb/tb_asic_iopwrseq.sv
// tb_asic_iopwrseq: directed literal checks plus randomized run against a segment-count model
module tb_asic_iopwrseq;
    localparam int NSEG  = 4;
    localparam int NCTRL = 8;
    localparam int CNTW  = 8;
    localparam int SW    = 2;

    localparam int OFF = 0, WAITPG = 1, SETL = 2, ON = 3, DN = 4, FLT = 5;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic [NCTRL-1:0]      cfg = '0;
    logic [CNTW-1:0]       settle_cycles = 8'd4, timeout_cycles = 8'd20;
    logic [NSEG-1:0]       pg = '1;
    logic [NSEG-1:0]       seg_en;
    logic [NSEG*NCTRL-1:0] ctrlring;
    logic                  busy, ready, fault;
    logic [SW-1:0]         fault_seg;

    int vectors = 0, miscompares = 0;
    int mode = OFF, m = 0, t = 0, fseg = 0;
    logic [NCTRL-1:0] cfgm = '0;

    asic_iopwrseq #(.NSEG(NSEG), .NCTRL(NCTRL), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .cfg(cfg), .settle_cycles(settle_cycles), .timeout_cycles(timeout_cycles),
        .pg(pg), .seg_en(seg_en), .ctrlring(ctrlring), .busy(busy), .ready(ready),
        .fault(fault), .fault_seg(fault_seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_low(input int lim);
        for (int i = 0; i < lim; i++)
            if (!pg[i]) return i;
        return -1;
    endfunction

    task automatic go_fault(input int i);
        mode = FLT;
        m    = 0;
        fseg = i;
    endtask

    // model: the ring is described only by how many segments are on and what phase we are in
    always @(posedge clk or posedge reset) begin : model
        int s, b;
        if (reset) begin
            mode = OFF; m = 0; t = 0; fseg = 0; cfgm = '0;
        end else begin
            s = (settle_cycles == 0) ? 1 : int'(settle_cycles);
            b = (mode == WAITPG) ? first_low(m - 1) :
                (mode == SETL)   ? first_low(m) :
                (mode == ON)     ? first_low(NSEG) : -1;
            if (b >= 0) go_fault(b);
            else if (mode == WAITPG && !pg[m-1] && t == int'(timeout_cycles)) go_fault(m - 1);
            else if ((mode == WAITPG || mode == SETL || mode == ON) && stop) begin
                m--; t = 0; mode = (m == 0) ? OFF : DN;
            end else begin
                case (mode)
                    OFF: if (start && !stop) begin m = 1; t = 0; cfgm = cfg; mode = WAITPG; end
                    WAITPG: if (pg[m-1]) begin t = 0; mode = SETL; end else t = (t + 1) & 255;
                    SETL: begin
                        if (t == s - 1) begin
                            t = 0;
                            if (m == NSEG) mode = ON; else begin m++; mode = WAITPG; end
                        end else t = (t + 1) & 255;
                    end
                    DN: begin
                        if (t == s - 1) begin t = 0; m--; if (m == 0) mode = OFF; end
                        else t = (t + 1) & 255;
                    end
                    FLT: if (clear) mode = OFF;
                    default: ;
                endcase
            end
        end
    end

    // compare every output against the model on each falling edge
    always @(negedge clk) begin : cmp
        logic [NSEG*NCTRL-1:0] ring;
        ring = '0;
        for (int i = 0; i < NSEG; i++)
            if (i < m) ring[i*NCTRL +: NCTRL] = cfgm;
        check("seg_en", 64'(seg_en), 64'((1 << m) - 1));
        check("ctrlring", 64'(ctrlring), 64'(ring));
        check("busy", 64'(busy), 64'(mode == WAITPG || mode == SETL || mode == DN));
        check("ready", 64'(ready), 64'(mode == ON));
        check("fault", 64'(fault), 64'(mode == FLT));
        if (mode == FLT) check("fault_seg", 64'(fault_seg), 64'(fseg));
    end

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        edges(1);
        start = 1'b0;
    endtask

    int hold;

    initial begin
        edges(2);
        reset = 1'b0;
        check("reset_seg_en", 64'(seg_en), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);

        // power-up, S=4
        cfg = 8'hA5; settle_cycles = 8'd4; timeout_cycles = 8'd20; pg = 4'hF;
        do_start();
        cfg = 8'h3C;
        check("pu_e0_seg", 64'(seg_en), 64'h1);
        check("pu_e0_busy", 64'(busy), 64'h1);
        check("pu_e0_ring", 64'(ctrlring), 64'h000000A5);
        edges(5);
        check("pu_e5_seg", 64'(seg_en), 64'h3);
        check("pu_e5_ring", 64'(ctrlring), 64'h0000A5A5);
        edges(5);
        check("pu_e10_seg", 64'(seg_en), 64'h7);
        edges(5);
        check("pu_e15_seg", 64'(seg_en), 64'hF);
        edges(4);
        check("pu_e19_ready", 64'(ready), 64'h0);
        edges(1);
        check("pu_e20_ready", 64'(ready), 64'h1);
        check("pu_e20_ring", 64'(ctrlring), 64'hA5A5A5A5);

        // power-down with pg dropping during DOWN
        stop = 1'b1;
        edges(1);
        stop = 1'b0;
        pg = 4'h0;
        check("pd_s_seg", 64'(seg_en), 64'h7);
        edges(4);
        check("pd_s4_seg", 64'(seg_en), 64'h3);
        edges(4);
        check("pd_s8_seg", 64'(seg_en), 64'h1);
        check("pd_s8_fault", 64'(fault), 64'h0);
        edges(4);
        check("pd_s12_seg", 64'(seg_en), 64'h0);
        check("pd_s12_busy", 64'(busy), 64'h0);

        // ramp timeout on segment 0
        timeout_cycles = 8'd10;
        do_start();
        edges(10);
        check("to_e10_fault", 64'(fault), 64'h0);
        edges(1);
        check("to_e11_fault", 64'(fault), 64'h1);
        check("to_fseg", 64'(fault_seg), 64'h0);
        check("to_seg", 64'(seg_en), 64'h0);
        start = 1'b1; pg = 4'hF;
        edges(3);
        start = 1'b0;
        check("to_start_ign", 64'(fault), 64'h1);
        clear = 1'b1;
        edges(1);
        clear = 1'b0;
        check("to_clear", 64'(fault), 64'h0);

        // pg drop in UP together with stop
        timeout_cycles = 8'd20;
        do_start();
        edges(20);
        check("drop_ready", 64'(ready), 64'h1);
        pg = 4'b1011; stop = 1'b1;
        edges(1);
        stop = 1'b0; pg = 4'hF;
        check("drop_fault", 64'(fault), 64'h1);
        check("drop_fseg", 64'(fault_seg), 64'h2);
        check("drop_seg", 64'(seg_en), 64'h0);
        clear = 1'b1;
        edges(1);
        clear = 1'b0;

        // start and stop together
        start = 1'b1; stop = 1'b1;
        edges(1);
        start = 1'b0; stop = 1'b0;
        check("ss_busy", 64'(busy), 64'h0);
        check("ss_seg", 64'(seg_en), 64'h0);

        // settle_cycles=0 behaves as S=1
        settle_cycles = 8'd0;
        do_start();
        edges(2);
        check("s0_e2_seg", 64'(seg_en), 64'h3);
        edges(6);
        check("s0_e8_ready", 64'(ready), 64'h1);
        stop = 1'b1;
        edges(1);
        stop = 1'b0;
        edges(3);
        check("s0_down_busy", 64'(busy), 64'h0);
        check("s0_down_seg", 64'(seg_en), 64'h0);

        // asynchronous reset during SETTLE of segment 2
        settle_cycles = 8'd4; cfg = 8'h5A;
        do_start();
        edges(12);
        #2 reset = 1'b1;
        #1;
        check("ar_seg", 64'(seg_en), 64'h0);
        check("ar_ring", 64'(ctrlring), 64'h0);
        check("ar_busy", 64'(busy), 64'h0);
        #3 reset = 1'b0;
        edges(1);
        do_start();
        check("ar_restart_seg", 64'(seg_en), 64'h1);
        edges(20);
        check("ar_restart_ready", 64'(ready), 64'h1);
        check("ar_restart_ring", 64'(ctrlring), 64'h5A5A5A5A);

        // randomized run
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 49) == 0);
            clear = ($urandom_range(0, 5) == 0);
            cfg   = NCTRL'($urandom);
            if ((mode == OFF || mode == ON) && $urandom_range(0, 9) == 0) begin
                settle_cycles  = CNTW'($urandom_range(0, 3));
                timeout_cycles = CNTW'($urandom_range(2, 12));
            end
            if (hold > 0) hold--;
            else if ($urandom_range(0, 39) == 0) begin
                pg = NSEG'($urandom);
                hold = $urandom_range(1, 15);
            end else pg = '1;
            edges(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/asic_iopwrseq.md
# asic_iopwrseq

Padring power-up/power-down sequencer for a pad ring split into NSEG supply segments by iocut cells. It enables segments in order and drives each enabled segment's control ring with a latched configuration word. Each segment must report power-good before the next one is enabled. Segments shut down in reverse order, and any power-good loss or ramp timeout forces the whole ring off and latches a fault. It sits in the chip top between the power-management CSRs and the padring ctrlring nets.

## Interface
- NSEG, 4, number of supply segments (≥1)
- NCTRL, 8, control-ring width per segment
- CNTW, 8, width of the settle and timeout counters
- SW, $clog2(NSEG) (min 1), segment index width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  pulse or level, begin power-up (sampled in IDLE only)
- stop  in  1  begin power-down (sampled in RAMP/SETTLE/UP)
- clear  in  1  leave FAULT
- cfg  in  NCTRL  control word; latched into cfg_q on the start-sampling edge
- settle_cycles  in  CNTW  settle time per segment; 0 is treated as 1
- timeout_cycles  in  CNTW  power-good wait limit
- pg  in  NSEG  per-segment power-good sense; synchronous to clk
- seg_en  out  NSEG  segment supply enable
- ctrlring  out  NSEG*NCTRL  segment i slice = seg_en[i] ? cfg_q : 0
- busy  out  1  state is RAMP, SETTLE or DOWN
- ready  out  1  state is UP
- fault  out  1  state is FAULT
- fault_seg  out  SW  failing segment index; valid while fault is high

## Operation
- The state machine has states IDLE, RAMP, SETTLE, UP, DOWN and FAULT. It uses registers idx (SW bits) and cnt (CNTW bits). All outputs are registered.
- **IDLE:**
  - seg_en is 0.
  - If start=1 and stop=0: latch cfg_q, set idx=0, set seg_en[0]=1, set cnt=0, go to RAMP.
  - If start and stop are both high, stop wins and the block stays in IDLE.
- **RAMP:**
  - If pg[idx]=1: set cnt=0, go to SETTLE.
  - Else if cnt==timeout_cycles: go to FAULT.
  - Otherwise increment cnt.
- **SETTLE:** lasts S = max(settle_cycles,1) cycles.
  - If cnt==S-1 and idx==NSEG-1: go to UP.
  - If cnt==S-1 and idx<NSEG-1: increment idx, set seg_en[idx+1]=1, set cnt=0, go to RAMP.
- **UP:** holds with all seg_en bits at 1.
- **Power-good monitor:**
  - In RAMP, SETTLE and UP, pg low on any already-settled segment (index < idx, or all segments in UP) goes to FAULT.
  - In SETTLE, pg[idx] low also goes to FAULT.
  - fault_seg gets the lowest failing index. For a ramp timeout, fault_seg = idx.
- **stop** in RAMP, SETTLE or UP: clear the highest set seg_en bit, set cnt=0, go to DOWN.
- **DOWN:**
  - pg is ignored and stop is ignored.
  - On cnt==S-1, clear the next highest set bit and set cnt=0.
  - When the bit cleared is bit 0, go to IDLE. The last clear and the IDLE entry happen on the same edge.
  - If stop arrives when only seg_en[0] is set, it clears bit 0 and goes directly to IDLE.
- **FAULT:**
  - seg_en is cleared to 0 on the entry edge, and fault=1.
  - start and stop are ignored.
  - clear=1 goes to IDLE and sets fault=0.
- **Priority** within one cycle: fault detection > stop > normal progress.
- **cfg and the counter fields:**
  - cfg changes after the start-sampling edge have no effect until the next start.
  - settle_cycles and timeout_cycles are sampled live every cycle.
- **Reset** (async, any state):
  - State goes to IDLE.
  - seg_en, ctrlring, busy, ready, fault, fault_seg, cnt, idx and cfg_q go to 0.
  - All are zero immediately on reset assertion.

## Timing
- Edge 0 is the start-sampling edge. seg_en[0] and busy are high after edge 0.
- With pg tied high, each segment takes 1 RAMP cycle plus S SETTLE cycles. seg_en[k] rises after edge k·(S+1). ready rises after edge NSEG·(S+1).
- A ramp timeout asserts fault after edge timeout_cycles+1, counted from the RAMP entry edge.
- A pg drop sampled at edge n gives fault=1 and seg_en=0 after edge n: 1-cycle latency.
- Power-down: stop sampled at edge s clears the top bit at s. Each following bit clears S edges later. seg_en=0 and IDLE after edge s+(m-1)·S, where m is the number of bits set at stop.
- ctrlring follows seg_en in the same cycle, because both are registered on the same edge.

## Test plan
- **Power-up:** NSEG=4, S=4, pg tied high, cfg=8'hA5, start at edge 0 → seg_en = 0001, 0011, 0111, 1111 after edges 0, 5, 10, 15. ready after edge 20. Each enabled slice is 8'hA5, disabled slices are 0.
- **Ramp timeout:** timeout_cycles=10, pg[0] held low → fault after edge 11, fault_seg=0, seg_en=0. start is ignored until clear; clear returns the block to IDLE.
- **pg drop in UP:** from UP, pg[2] pulled low at edge n → fault after edge n, fault_seg=2, seg_en=0. Also assert stop at edge n: fault still wins.
- **Power-down:** stop in UP, S=4 → seg_en = 0111, 0011, 0001, 0000 at s, s+4, s+8, s+12. IDLE and busy=0 at s+12. A pg drop during DOWN causes no fault.
- **Edge cases:**
  - start and stop together in IDLE → stays IDLE.
  - settle_cycles=0 behaves as S=1.
  - NSEG=1 build reaches ready after edge S+1.
- **Reset mid-operation:** assert reset asynchronously during SETTLE of segment 2 → all outputs 0 before the next edge. After reset release, start repeats the full sequence from segment 0.
